// File: rtl/pcie_mwr_tlp_gen.sv
// One-DW PCIe Memory Write TLP generator: takes one posted write from the request
// arbiter, streams it as a 3DW or 4DW TLP on the 64-bit AXI4-Stream TX port, then acks.
module pcie_mwr_tlp_gen #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_data_i,
  input  logic                  req_valid_i,
  output logic                  req_ack_o,
  input  logic [15:0]           cfg_completer_id_i,
  input  logic                  cfg_bus_master_en_i,
  output logic [63:0]           tx_tdata_o,
  output logic [7:0]            tx_tkeep_o,
  output logic                  tx_tlast_o,
  output logic                  tx_tvalid_o,
  input  logic                  tx_tready_i,
  output logic [31:0]           tlp_count_o
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, ACK} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        is4_q, is4_d;
  logic [7:0]  tag_q, tag_d;
  logic [31:0] count_q, count_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic        ack_q, ack_d;

  logic [63:0] req_addr_ext;
  logic        handshake;
  logic        unused_addr_bits;

  // A 32-bit address build zero-extends, so it always produces 3DW headers.
  if (ADDR_WIDTH == 64) begin : g_addr64
    assign req_addr_ext = req_addr_i;
  end else begin : g_addr32
    assign req_addr_ext = {{(64-ADDR_WIDTH){1'b0}}, req_addr_i};
  end

  assign unused_addr_bits = ^req_addr_ext[1:0];
  assign handshake        = tvalid_q & tx_tready_i;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    is4_d    = is4_q;
    tag_d    = tag_q;
    count_d  = count_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid_i && cfg_bus_master_en_i) begin
          addr_d   = {req_addr_ext[63:2], 2'b00};
          data_d   = req_data_i;
          is4_d    = (req_addr_ext[63:32] != 32'h0);
          tdata_d  = {cfg_completer_id_i, tag_q, 4'h0, 4'hF,
                      (is4_d ? 32'h6000_0001 : 32'h4000_0001)};
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          tvalid_d = 1'b1;
          state_d  = BEAT0;
        end
      end
      BEAT0: begin
        if (handshake) begin
          tkeep_d = 8'hFF;
          if (is4_q) begin
            tdata_d = {addr_q[31:0], addr_q[63:32]};
            tlast_d = 1'b0;
          end else begin
            tdata_d = {data_q, addr_q[31:0]};
            tlast_d = 1'b1;
          end
          state_d = BEAT1;
        end
      end
      BEAT1: begin
        if (handshake) begin
          if (is4_q) begin
            tdata_d = {32'h0, data_q};
            tkeep_d = 8'h0F;
            tlast_d = 1'b1;
            state_d = BEAT2;
          end else begin
            tdata_d  = 64'h0;
            tkeep_d  = 8'h00;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
            ack_d    = 1'b1;
            state_d  = ACK;
          end
        end
      end
      BEAT2: begin
        if (handshake) begin
          tdata_d  = 64'h0;
          tkeep_d  = 8'h00;
          tlast_d  = 1'b0;
          tvalid_d = 1'b0;
          ack_d    = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        // The arbiter still holds valid this cycle, so no acceptance here.
        tag_d   = tag_q + 8'd1;
        count_d = count_q + 32'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= 64'h0;
      data_q   <= 32'h0;
      is4_q    <= 1'b0;
      tag_q    <= 8'h0;
      count_q  <= 32'h0;
      tdata_q  <= 64'h0;
      tkeep_q  <= 8'h0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      is4_q    <= is4_d;
      tag_q    <= tag_d;
      count_q  <= count_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      ack_q    <= ack_d;
    end
  end

  assign req_ack_o   = ack_q;
  assign tx_tdata_o  = tdata_q;
  assign tx_tkeep_o  = tkeep_q;
  assign tx_tlast_o  = tlast_q;
  assign tx_tvalid_o = tvalid_q;
  assign tlp_count_o = count_q;

endmodule

// File: tb/tb_pcie_mwr_tlp_gen.sv
// Self-checking bench for pcie_mwr_tlp_gen: table vectors, handshake corner cases
// and a back-to-back run, all checked against a queue of expected TX beats.
module tb_pcie_mwr_tlp_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req_addr;
  logic [31:0] req_data;
  logic        req_valid;
  logic        req_ack;
  logic [15:0] cfg_id;
  logic        bm_en;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [31:0] tlp_count;

  always #5 clk = ~clk;

  pcie_mwr_tlp_gen #(.ADDR_WIDTH(64)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .req_addr_i          (req_addr),
    .req_data_i          (req_data),
    .req_valid_i         (req_valid),
    .req_ack_o           (req_ack),
    .cfg_completer_id_i  (cfg_id),
    .cfg_bus_master_en_i (bm_en),
    .tx_tdata_o          (tx_tdata),
    .tx_tkeep_o          (tx_tkeep),
    .tx_tlast_o          (tx_tlast),
    .tx_tvalid_o         (tx_tvalid),
    .tx_tready_i         (tx_tready),
    .tlp_count_o         (tlp_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic [15:0] id;
    logic        is4;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [63:0] b2;
    int          lat;
  } vec_t;

  beat_t       expQ[$];
  int          cmpCount = 0;
  int          errCount = 0;
  int          ackCount = 0;
  logic [7:0]  expTag;

  // Every comparison funnels through here so the summary counts stay exact.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushBeat(input logic [63:0] d, input logic [7:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    expQ.push_back(b);
  endtask

  // Reference TLP builder, written straight from the header/beat layout.
  task automatic pushModel(input logic [63:0] a, input logic [31:0] d,
                           input logic [15:0] id, input logic [7:0] tag);
    logic [31:0] h1;
    logic [31:0] alo;
    h1  = {id, tag, 8'h0F};
    alo = {a[31:2], 2'b00};
    if (a[63:32] != 32'h0) begin
      pushBeat({h1, 32'h6000_0001}, 8'hFF, 1'b0);
      pushBeat({alo, a[63:32]}, 8'hFF, 1'b0);
      pushBeat({32'h0, d}, 8'h0F, 1'b1);
    end else begin
      pushBeat({h1, 32'h4000_0001}, 8'hFF, 1'b0);
      pushBeat({d, alo}, 8'hFF, 1'b1);
    end
  endtask

  // Acts as the arbiter: holds the request until ack, scrambles addr/data after
  // the latch, keeps valid high through the ACK cycle, then drops it.
  task automatic applyStimulus(input logic [63:0] a, input logic [31:0] d,
                               input logic [15:0] id, output int lat);
    bit seen;
    seen      = 1'b0;
    req_addr  = a;
    req_data  = d;
    cfg_id    = id;
    req_valid = 1'b1;
    lat       = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        req_addr = ~a;
        req_data = ~d;
      end
      if (req_ack) seen = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Beat monitor: pops the scoreboard on every accepted beat.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_tvalid && tx_tready) begin
          if (expQ.size() == 0) begin
            cmpCount++;
            errCount++;
            $display("[TB] FAIL unexpected_beat: got beat 0x%016h, required no beat", tx_tdata);
          end else begin
            b = expQ.pop_front();
            checkOutput("beat_data", tx_tdata, b.data);
            checkOutput("beat_keep", {56'h0, tx_tkeep}, {56'h0, b.keep});
            checkOutput("beat_last", {63'h0, tx_tlast}, {63'h0, b.last});
          end
        end
        if (req_ack) begin
          ackCount++;
          checkOutput("ack_tvalid_low", {63'h0, tx_tvalid}, 64'h0);
        end
      end
    end
  end

  initial begin : main
    vec_t vecs[4];
    int   lat;
    int   bad;
    int   ackStart;
    logic [63:0] a;
    logic [31:0] d;

    vecs[0] = '{64'h0000_0000_1000_0004, 32'hDEAD_BEEF, 16'h0100, 1'b0,
                64'h0100000F_40000001, 64'hDEADBEEF_10000004, 64'h0, 4};
    vecs[1] = '{64'h0000_0002_8000_0013, 32'h1234_5678, 16'h0100, 1'b1,
                64'h0100010F_60000001, 64'h80000010_00000002, 64'h00000000_12345678, 5};
    vecs[2] = '{64'h0000_0000_FFFF_FFFF, 32'h0000_0000, 16'hABCD, 1'b0,
                64'hABCD020F_40000001, 64'h00000000_FFFFFFFC, 64'h0, 4};
    vecs[3] = '{64'hFFFF_FFFF_0000_0002, 32'hCAFE_F00D, 16'h1234, 1'b1,
                64'h1234030F_60000001, 64'h00000000_FFFFFFFF, 64'h00000000_CAFEF00D, 5};

    rst       = 1'b1;
    req_addr  = 64'h0;
    req_data  = 32'h0;
    req_valid = 1'b0;
    cfg_id    = 16'h0100;
    bm_en     = 1'b1;
    tx_tready = 1'b1;
    expTag    = 8'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", {63'h0, tx_tvalid}, 64'h0);
    checkOutput("rst_ack", {63'h0, req_ack}, 64'h0);
    checkOutput("rst_tdata", tx_tdata, 64'h0);
    checkOutput("rst_tkeep", {56'h0, tx_tkeep}, 64'h0);
    checkOutput("rst_tlast", {63'h0, tx_tlast}, 64'h0);
    checkOutput("rst_count", {32'h0, tlp_count}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      pushBeat(vecs[i].b0, 8'hFF, 1'b0);
      if (vecs[i].is4) begin
        pushBeat(vecs[i].b1, 8'hFF, 1'b0);
        pushBeat(vecs[i].b2, 8'h0F, 1'b1);
      end else begin
        pushBeat(vecs[i].b1, 8'hFF, 1'b1);
      end
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].id, lat);
      expTag++;
      checkOutput("vec_ack_latency", 64'(lat), 64'(vecs[i].lat));
      checkOutput("vec_count", {32'h0, tlp_count}, 64'(i + 1));
    end

    // Backpressure on beat1, with bus mastering dropped mid-TLP.
    pushBeat(64'h0100040F_40000001, 8'hFF, 1'b0);
    pushBeat(64'h55AA55AA_00002000, 8'hFF, 1'b1);
    req_addr  = 64'h0000_0000_0000_2000;
    req_data  = 32'h55AA_55AA;
    cfg_id    = 16'h0100;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_tready = 1'b0;
    bm_en     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_tvalid", {63'h0, tx_tvalid}, 64'h1);
      checkOutput("bp_tdata", tx_tdata, 64'h55AA55AA_00002000);
      checkOutput("bp_tlast", {63'h0, tx_tlast}, 64'h1);
      checkOutput("bp_ack", {63'h0, req_ack}, 64'h0);
      @(posedge clk);
      #1;
    end
    tx_tready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_ack", {63'h0, req_ack}, 64'h0);
    @(negedge clk);
    checkOutput("bp_ack_after_handshake", {63'h0, req_ack}, 64'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bm_en     = 1'b1;
    expTag++;
    checkOutput("bp_count", {32'h0, tlp_count}, 64'd5);

    // Bus mastering disabled: a pending request must be ignored.
    bm_en     = 1'b0;
    req_addr  = 64'h0000_0000_0000_3000;
    req_data  = 32'h0000_0001;
    req_valid = 1'b1;
    bad       = 0;
    ackStart  = ackCount;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_tvalid || req_ack) bad++;
    end
    checkOutput("bm_blocked_cycles", 64'(bad), 64'h0);
    @(posedge clk);
    #1;
    bm_en = 1'b1;
    pushModel(64'h0000_0000_0000_3000, 32'h0000_0001, 16'h0100, expTag);
    applyStimulus(64'h0000_0000_0000_3000, 32'h0000_0001, 16'h0100, lat);
    expTag++;
    checkOutput("bm_enable_latency", 64'(lat), 64'd4);
    checkOutput("bm_ack_count", 64'(ackCount - ackStart), 64'd1);

    // Reset while beat1 of a 4DW TLP is stalled on the bus.
    pushBeat(64'h0100060F_60000001, 8'hFF, 1'b0);
    req_addr  = 64'h0000_0001_0000_0000;
    req_data  = 32'h0000_0077;
    cfg_id    = 16'h0100;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_tready = 1'b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_tvalid", {63'h0, tx_tvalid}, 64'h0);
    checkOutput("midrst_ack", {63'h0, req_ack}, 64'h0);
    checkOutput("midrst_count", {32'h0, tlp_count}, 64'h0);
    checkOutput("midrst_queue_drained", 64'(expQ.size()), 64'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    tx_tready = 1'b1;
    expTag    = 8'h0;

    // 257 back-to-back requests: tags wrap 255 -> 0, one ack per TLP.
    ackStart = ackCount;
    for (int i = 0; i < 257; i++) begin
      d = $urandom;
      if (i % 2 == 1) a = {($urandom | 32'h1), $urandom};
      else            a = {32'h0, $urandom};
      pushModel(a, d, 16'h0100, expTag);
      applyStimulus(a, d, 16'h0100, lat);
      expTag++;
      checkOutput("b2b_latency", 64'(lat), (i % 2 == 1) ? 64'd5 : 64'd4);
    end
    checkOutput("b2b_count", {32'h0, tlp_count}, 64'd257);
    checkOutput("b2b_acks", 64'(ackCount - ackStart), 64'd257);
    repeat (4) @(negedge clk);
    checkOutput("b2b_queue_drained", 64'(expQ.size()), 64'h0);
    checkOutput("b2b_idle_tvalid", {63'h0, tx_tvalid}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
